// File: rtl/chunked_add_seq.sv
// Multi-cycle wide add/subtract that reuses one CHUNK-bit adder slice,
// least-significant chunk first, with the inter-chunk carry held in a register.
module chunked_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
      $error("chunked_add_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg;
  logic             out_ovf_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;
  logic             ovf_next;

  // Split the operands into chunks and splice the current slice result into
  // the accumulator so the final chunk can be committed on the same edge.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign acc_next[gi*CHUNK +: CHUNK] =
        (k_reg == KW'(gi)) ? chunk_sum : acc_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign {chunk_cout, chunk_sum} = {1'b0, a_chunks[k_reg]}
                                 + {1'b0, b_chunks[k_reg]}
                                 + {{CHUNK{1'b0}}, carry_reg};

  assign last_chunk = (k_reg == KW'(NCHUNK - 1));
  assign ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (acc_next[WIDTH-1] != a_reg[WIDTH-1]);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      carry_reg     <= 1'b0;
      k_reg         <= '0;
      out_sum_reg   <= '0;
      out_cout_reg  <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub | in_cin;
            k_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= chunk_cout;
          k_reg     <= k_reg + KW'(1);
          if (last_chunk) begin
            out_sum_reg   <= acc_next;
            out_cout_reg  <= chunk_cout;
            out_ovf_reg   <= ovf_next;
            out_valid_reg <= 1'b1;
            k_reg         <= '0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cout  = out_cout_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed plus random checks of chunked_add_seq against an arithmetic model
// built from unsigned/signed full-precision results.
module tb_chunked_add_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  chunked_add_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from exact integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    longint unsigned ua, ub, u;
    longint sa, sb, s;
    logic [31:0] sum;
    logic cout, ovf;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      sum  = a - b;
      cout = (ua >= ub);
      s    = sa - sb;
    end else begin
      u    = ua + ub + {63'd0, cin};
      sum  = u[31:0];
      cout = u[32];
      s    = sa + sb + longint'(cin);
    end
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ovf, cout, sum};
  endfunction

  // Present a request, take it on the next edge, then scramble the inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    in_cin = 1'($urandom); in_sub = 1'($urandom);
  endtask

  // Called #1 after the accepting edge; checks latency and result.
  task automatic wait_result(input string tag, input logic [33:0] exp);
    int cyc;
    check({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_sum"}, {32'd0, out_sum}, {32'd0, exp[31:0]});
    check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp[32]});
    check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, exp[33]});
    check({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] held);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_sum_hold"}, {32'd0, out_sum}, {32'd0, held});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
    logic [33:0] e;
    e = ref_op(a, b, cin, sub);
    start_op(a, b, cin, sub);
    wait_result(tag, e);
    finish_op(tag, e[31:0]);
  endtask

  initial begin
    logic [33:0] e;
    logic [31:0] ra, rb, na, nb;
    logic rc, rs;

    // Reset values before any clock edge.
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    run_op("basic", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    run_op("ripple1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("ripple_cin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    run_op("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b1);
    run_op("sub_min", 32'h80000000, 32'd1, 1'b1, 1'b1);

    // Backpressure: result must hold while a new request is waiting.
    e = ref_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
    start_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
    wait_result("bp_first", e);
    na = $urandom; nb = $urandom;
    in_a = na; in_b = nb; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      check("bp_sum_hold", {32'd0, out_sum}, {32'd0, e[31:0]});
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = ref_op(na, nb, 1'b0, 1'b1);
    wait_result("bp_second", e);
    finish_op("bp_second", e[31:0]);

    // Random operations with random consumer stalls.
    for (int i = 0; i < 25; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 5 == 0) rb = ra ^ 32'h80000000;
      e = ref_op(ra, rb, rc, rs);
      start_op(ra, rb, rc, rs);
      wait_result("rand", e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("rand_stall_sum", {32'd0, out_sum}, {32'd0, e[31:0]});
      finish_op("rand", e[31:0]);
    end

    // Asynchronous reset two cycles into RUN.
    start_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_sum", {32'd0, out_sum}, 64'd0);
    check("mid_rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("mid_rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    check("post_rst_fixed_sum", {32'd0, out_sum}, 64'h23456789);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
